// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-generation stage: format codes,
// RV32 major opcodes and the XLEN legality check.
package imm_pkg;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_Z    = 3'd6
   } fmt_e;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   function automatic bit xlen_legal(input int xlen);
      return (xlen == 32) || (xlen == 64);
   endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode-to-format decode and immediate extraction, extended
// to XLEN bits.
module imm_decode
   import imm_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter bit ZIMM_EN = 1'b1
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output fmt_e            fmt
);

   if (!xlen_legal(XLEN)) begin : g_xlen_check
      $error("imm_decode: XLEN must be 32 or 64");
   end

   logic signed [31:0] raw;

   // Every immediate is first formed at 32 bits, then widened by sign extension.
   function automatic logic [XLEN-1:0] sext_xlen(input logic signed [31:0] v);
      logic signed [XLEN-1:0] w;
      w = XLEN'(v);
      return w;
   endfunction

   always_comb begin
      fmt = FMT_NONE;
      unique case (instr[6:0])
         OP_IMM, OP_LOAD, OP_JALR, OP_IMM32: fmt = FMT_I;
         OP_STORE:                           fmt = FMT_S;
         OP_BRANCH:                          fmt = FMT_B;
         OP_LUI, OP_AUIPC:                   fmt = FMT_U;
         OP_JAL:                             fmt = FMT_J;
         OP_SYSTEM:                          fmt = (ZIMM_EN && instr[14]) ? FMT_Z : FMT_I;
         default:                            fmt = FMT_NONE;
      endcase
   end

   always_comb begin
      raw = '0;
      unique case (fmt)
         FMT_I:   raw = {{20{instr[31]}}, instr[31:20]};
         FMT_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   raw = {instr[31:12], 12'b0};
         FMT_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         FMT_Z:   raw = {27'b0, instr[19:15]};
         default: raw = '0;
      endcase
   end

   assign imm = sext_xlen(raw);

endmodule

// File: rtl/imm_gen_stage.sv
// Decode-at-input immediate generator with an output register plus a
// one-entry skid register; in_ready depends only on skid occupancy.
module imm_gen_stage
   import imm_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TAG_W   = 32,
   parameter bit ZIMM_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [TAG_W-1:0] out_tag,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt
);

   logic [XLEN-1:0]  imm_p0;
   fmt_e             fmt_p0;

   logic             vld_p1, vld_p1_nxt;
   logic [31:0]      instr_p1;
   logic [TAG_W-1:0] tag_p1;
   logic [XLEN-1:0]  imm_p1;
   fmt_e             fmt_p1;

   logic             skid_vld, skid_vld_nxt;
   logic [31:0]      skid_instr;
   logic [TAG_W-1:0] skid_tag;
   logic [XLEN-1:0]  skid_imm;
   fmt_e             skid_fmt;

   logic accept, drain, load_from_in, load_from_skid, load_skid;

   // ---- p0: decode the incoming word; only decoded results are buffered
   imm_decode #(
      .XLEN    (XLEN),
      .ZIMM_EN (ZIMM_EN)
   ) u_decode (
      .instr (in_instr),
      .imm   (imm_p0),
      .fmt   (fmt_p0)
   );

   assign accept = in_valid && in_ready && !flush;
   assign drain  = vld_p1 && out_ready;

   always_comb begin
      vld_p1_nxt     = vld_p1;
      skid_vld_nxt   = skid_vld;
      load_from_in   = 1'b0;
      load_from_skid = 1'b0;
      load_skid      = 1'b0;
      if (!vld_p1 || drain) begin
         if (skid_vld) begin
            load_from_skid = 1'b1;
            skid_vld_nxt   = 1'b0;
            vld_p1_nxt     = 1'b1;
         end else if (accept) begin
            load_from_in = 1'b1;
            vld_p1_nxt   = 1'b1;
         end else begin
            vld_p1_nxt = 1'b0;
         end
      end else if (accept) begin
         load_skid    = 1'b1;
         skid_vld_nxt = 1'b1;
      end
      if (flush) begin
         vld_p1_nxt   = 1'b0;
         skid_vld_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1   <= 1'b0;
         skid_vld <= 1'b0;
         in_ready <= 1'b1;
      end else begin
         vld_p1   <= vld_p1_nxt;
         skid_vld <= skid_vld_nxt;
         in_ready <= !skid_vld_nxt;
      end
   end

   // ---- p1: output register, refilled from skid first to preserve order
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_p1 <= '0;
         tag_p1   <= '0;
         imm_p1   <= '0;
         fmt_p1   <= FMT_NONE;
      end else if (load_from_skid) begin
         instr_p1 <= skid_instr;
         tag_p1   <= skid_tag;
         imm_p1   <= skid_imm;
         fmt_p1   <= skid_fmt;
      end else if (load_from_in) begin
         instr_p1 <= in_instr;
         tag_p1   <= in_tag;
         imm_p1   <= imm_p0;
         fmt_p1   <= fmt_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (load_skid) begin
         skid_instr <= in_instr;
         skid_tag   <= in_tag;
         skid_imm   <= imm_p0;
         skid_fmt   <= fmt_p0;
      end
   end

   assign out_valid = vld_p1;
   assign out_instr = instr_p1;
   assign out_tag   = tag_p1;
   assign out_imm   = imm_p1;
   assign out_fmt   = fmt_p1;

endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 Parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 Parameter TAG_W, default 32, width of the sideband tag (typically PC) carried with each instruction.
REQ-003 Parameter ZIMM_EN, default 1; when 1, CSR-immediate forms produce format Z, otherwise format I.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  synchronous discard of all buffered entries.
REQ-007 in_valid  input  1  upstream instruction valid.
REQ-008 in_ready  output  1  stage can accept an instruction.
REQ-009 in_instr  input  32  raw RV32 instruction word.
REQ-010 in_tag  input  TAG_W  sideband tag.
REQ-011 out_valid  output  1  decoded entry valid.
REQ-012 out_ready  input  1  downstream accepts.
REQ-013 out_instr  output  32  instruction passed through.
REQ-014 out_tag  output  TAG_W  tag passed through.
REQ-015 out_imm  output  XLEN  extended immediate.
REQ-016 out_fmt  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.

Function
REQ-017 Opcode decode: 0010011/0000011/1100111/0011011 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 1110011 -> Z if ZIMM_EN and funct3[2]=1, else I; all others -> NONE.
REQ-018 Immediate values: I = sign-extend instr[31:20]; S = sign-extend {instr[31:25],instr[11:7]}; B = sign-extend {instr[31],instr[7],instr[30:25],instr[11:8],0}; J = sign-extend {instr[31],instr[19:12],instr[20],instr[30:21],0}; U = sign-extend {instr[31:12],12'b0} to XLEN; Z = zero-extend instr[19:15]; NONE = 0.
REQ-019 All sign extension replicates instr[31] to the full XLEN width.
REQ-020 Transfer occurs on a cycle where valid and ready are both high, on the respective port.
REQ-021 Latency 1 cycle: an entry accepted at edge N is presented on out_* after edge N when the output register is empty or draining.
REQ-022 Throughput is 1 entry per cycle while out_ready stays high.
REQ-023 Buffering is an output register plus a one-entry skid register; capacity is 2 entries.
REQ-024 in_ready is a registered signal, equal to NOT skid_full; it has no combinational path from out_ready.
REQ-025 When an accept occurs with the output register occupied and not draining, the entry goes to the skid register.
REQ-026 When the output register drains and the skid register is full, the skid entry moves to the output register in the same edge.
REQ-027 Entries leave in acceptance order; no entry is duplicated or dropped.
REQ-028 out_* are stable while out_valid=1 and out_ready=0.
REQ-029 flush=1 clears both entries at the edge: out_valid=0 and in_ready=1 next cycle; an input presented in the same cycle is discarded.
REQ-030 A downstream accept in the same cycle as flush is still a valid transfer.

Reset
REQ-031 rst=1 at a clock edge: out_valid=0, in_ready=1, skid empty, out_imm=0, out_fmt=NONE, out_instr=0, out_tag=0.
REQ-032 Reset mid-operation discards all buffered entries; rst has priority over flush and handshakes.
REQ-033 While rst=1, in_ready=0 is not required; in_ready is 1 from the first cycle after reset.

Structure
REQ-034 Shared package imm_pkg holds the fmt_e encoding, the opcode constants, and XLEN legality checking.
REQ-035 Combinational extraction lives in sub-module imm_decode (instr -> imm, fmt; parameter XLEN, ZIMM_EN).
REQ-036 Decode is applied at input, before buffering; only decoded results are stored.

Verification
REQ-037 XLEN=32, 0xFFF00093 (addi) -> out_imm 0xFFFFFFFF, fmt I; 0x123450B7 (lui) -> 0x12345000, fmt U, each 1 cycle later.
REQ-038 0xFE000EE3 (beq -4) -> out_imm 0xFFFFFFFC, fmt B; 0xFE112C23 (sw -8) -> 0xFFFFFFF8, fmt S; XLEN=64 beq -> 0xFFFFFFFFFFFFFFFC.
REQ-039 0x3002D073 (csrrwi uimm 5) -> out_imm 5, fmt Z; with ZIMM_EN=0 -> out_imm 0x00000300, fmt I; opcode 0110011 -> imm 0, fmt NONE.
REQ-040 Backpressure: stream A,B,C with out_ready=0 -> A held on outputs, B in skid, in_ready=0, C stalls; out_ready=1 -> A,B,C emitted in order on consecutive cycles.
REQ-041 Flush with 2 entries buffered and in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry appears.
REQ-042 rst asserted for one cycle during a stream -> all outputs at REQ-031 values; next accepted instruction emitted normally.
